// File: rtl/inst_sram_axi_rd_bridge.sv
// Read-only bridge from the IF-stage sram-like inst port to an AXI4 AR/R channel pair.
// Issues single-beat reads, keeps up to MAX_OUTST in flight, returns data in request order.
module inst_sram_axi_rd_bridge #(
   parameter int unsigned MAX_OUTST = 2,
   parameter logic [3:0]  ARID_VAL  = 4'd0
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic {
      AR_IDLE,
      AR_BUSY
   } ar_state_t;

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

   ar_state_t   ar_state;
   logic [1:0]  outst_cnt;
   logic [1:0]  ar_size;
   logic        can_issue;
   logic        ar_hs;
   logic        r_last_hs;

   // Single ARID: ordering is implied, so ID and response code are not inspected.
   logic unused_inputs;
   assign unused_inputs = ^{rid, rresp};

   always_comb begin
      can_issue         = (ar_state == AR_IDLE) && (outst_cnt < MAX_CNT);
      // resetn gating keeps the grant low for the whole time reset is held
      inst_sram_addr_ok = resetn & inst_sram_req & ~inst_sram_wr & can_issue;
      rready            = (outst_cnt != 2'd0);
      ar_hs             = arvalid & arready;
      r_last_hs         = rvalid & rready & rlast;
      inst_sram_data_ok = r_last_hs;
      inst_sram_rdata   = rdata;
      arid              = ARID_VAL;
      arlen             = '0;
      arsize            = {1'b0, ar_size};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ar_state <= AR_IDLE;
         arvalid  <= 1'b0;
         araddr   <= '0;
         ar_size  <= '0;
      end else begin
         case (ar_state)
            AR_IDLE: begin
               if (inst_sram_addr_ok) begin
                  araddr   <= inst_sram_addr;
                  ar_size  <= inst_sram_size;
                  arvalid  <= 1'b1;
                  ar_state <= AR_BUSY;
               end
            end
            AR_BUSY: begin
               if (arready) begin
                  arvalid  <= 1'b0;
                  ar_state <= AR_IDLE;
               end
            end
            default: begin
               arvalid  <= 1'b0;
               ar_state <= AR_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outst_cnt <= '0;
      end else begin
         case ({ar_hs, r_last_hs})
            2'b10:   outst_cnt <= outst_cnt + 2'd1;
            2'b01:   outst_cnt <= outst_cnt - 2'd1;
            default: outst_cnt <= outst_cnt;
         endcase
      end
   end

   a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
      outst_cnt <= MAX_CNT);

   a_ar_stable: assert property (@(posedge clk) disable iff (!resetn)
      (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arsize)));

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Directed bench for inst_sram_axi_rd_bridge: per-cycle comparison against a
// transaction-level model plus hand-computed expectations for each scenario.
module tb_inst_sram_axi_rd_bridge;

   localparam int unsigned MAX  = 2;
   localparam logic [3:0]  ARID = 4'h5;

   logic        clk;
   logic        resetn;
   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic        addr_ok, data_ok;
   logic [31:0] sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   inst_sram_axi_rd_bridge #(.MAX_OUTST(MAX), .ARID_VAL(ARID)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .inst_sram_req     (req),
      .inst_sram_wr      (wr),
      .inst_sram_size    (size),
      .inst_sram_addr    (addr),
      .inst_sram_addr_ok (addr_ok),
      .inst_sram_data_ok (data_ok),
      .inst_sram_rdata   (sram_rdata),
      .arid              (arid),
      .araddr            (araddr),
      .arlen             (arlen),
      .arsize            (arsize),
      .arvalid           (arvalid),
      .arready           (arready),
      .rid               (rid),
      .rdata             (rdata),
      .rresp             (rresp),
      .rlast             (rlast),
      .rvalid            (rvalid),
      .rready            (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
   endtask

   // Model: requests granted but not yet on AR, and reads in flight
   int          m_cnt;
   bit          m_pend;
   logic [31:0] m_addr;
   logic [1:0]  m_size;
   logic        e_aok, e_rr, e_dok;
   bit          m_ar_hs;

   int          n_aok = 0, n_dok = 0, n_arv = 0;
   logic [31:0] last_rdata, last_araddr;
   logic [2:0]  last_arsize;
   logic [7:0]  last_arlen;

   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
         chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
         chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
         chk("rst_rready",  {31'd0, rready},  32'd0);
         chk("rst_araddr",  araddr, 32'd0);
         chk("rst_arsize",  {29'd0, arsize}, 32'd0);
         m_cnt  = 0;
         m_pend = 0;
         m_addr = '0;
         m_size = '0;
      end else begin
         e_aok = req && !wr && !m_pend && (m_cnt < int'(MAX));
         e_rr  = (m_cnt != 0);
         e_dok = rvalid && e_rr && rlast;
         chk("addr_ok", {31'd0, addr_ok}, {31'd0, e_aok});
         chk("arvalid", {31'd0, arvalid}, {31'd0, m_pend});
         chk("rready",  {31'd0, rready},  {31'd0, e_rr});
         chk("data_ok", {31'd0, data_ok}, {31'd0, e_dok});
         chk("araddr",  araddr, m_addr);
         chk("arsize",  {29'd0, arsize}, {30'd0, m_size});
         chk("arlen",   {24'd0, arlen}, 32'd0);
         chk("arid",    {28'd0, arid}, {28'd0, ARID});
         chk("rdata_passthru", sram_rdata, rdata);
         if (addr_ok) n_aok++;
         if (data_ok) begin
            n_dok++;
            last_rdata = sram_rdata;
         end
         if (arvalid) begin
            n_arv++;
            last_araddr = araddr;
            last_arsize = arsize;
            last_arlen  = arlen;
         end
         m_ar_hs = m_pend && arready;
         if (e_aok) begin
            m_pend = 1;
            m_addr = addr;
            m_size = size;
         end else if (m_ar_hs) begin
            m_pend = 0;
         end
         m_cnt = m_cnt + int'(m_ar_hs) - int'(e_dok);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int a0, d0, v0;

   task automatic snap();
      a0 = n_aok;
      d0 = n_dok;
      v0 = n_arv;
   endtask

   initial begin
      resetn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1c00_0000;
      arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
      tick(); tick();
      chk("reset_hold_addr_ok", {31'd0, addr_ok}, 32'd0);
      req = 1'b0; resetn = 1'b1;
      tick();

      // single fetch
      snap();
      req = 1'b1; addr = 32'h1c00_0000; size = 2'd2;
      tick();
      req = 1'b0; arready = 1'b1;
      tick();
      arready = 1'b0;
      tick();
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0280_0c0c;
      tick();
      rvalid = 1'b0; rlast = 1'b0; rdata = '0;
      tick();
      chk("t1_addr_ok_count", n_aok - a0, 1);
      chk("t1_arvalid_cycles", n_arv - v0, 1);
      chk("t1_data_ok_count", n_dok - d0, 1);
      chk("t1_rdata", last_rdata, 32'h0280_0c0c);
      chk("t1_araddr", last_araddr, 32'h1c00_0000);
      chk("t1_arsize", {29'd0, last_arsize}, 32'd2);
      chk("t1_arlen", {24'd0, last_arlen}, 32'd0);
      chk("t1_rready_idle", {31'd0, rready}, 32'd0);

      // AR back-pressure: 5 stalled cycles then handshake
      snap();
      req = 1'b1; addr = 32'h1c00_0040; size = 2'd2;
      tick();
      for (int i = 0; i < 5; i++) begin
         addr = 32'h1c00_0800 + 32'(i);
         tick();
      end
      req = 1'b0; arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("t2_arvalid_cycles", n_arv - v0, 6);
      chk("t2_addr_ok_count", n_aok - a0, 1);
      chk("t2_araddr", last_araddr, 32'h1c00_0040);
      chk("t2_rready_after_hs", {31'd0, rready}, 32'd1);
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'hdead_beef;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      chk("t2_data_ok_count", n_dok - d0, 1);
      chk("t2_rdata", last_rdata, 32'hdead_beef);
      chk("t2_rready_drained", {31'd0, rready}, 32'd0);

      // outstanding limit
      snap();
      req = 1'b1; arready = 1'b1; size = 2'd2;
      for (int i = 0; i < 8; i++) begin
         addr = 32'h1c00_0100 + 32'(4 * i);
         tick();
      end
      chk("t3_addr_ok_at_limit", n_aok - a0, 2);
      chk("t3_arvalid_at_limit", {31'd0, arvalid}, 32'd0);
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1111_2222;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      chk("t3_no_grant_same_cycle", n_aok - a0, 2);
      tick();
      chk("t3_third_grant", n_aok - a0, 3);
      req = 1'b0;
      tick();
      arready = 1'b0;
      chk("t3_third_araddr", last_araddr, 32'h1c00_011c);
      snap();
      rvalid = 1'b1; rlast = 1'b1;
      tick(); tick();
      rvalid = 1'b0; rlast = 1'b0;
      chk("t3_drain_data_ok", n_dok - d0, 2);
      chk("t3_rready_drained", {31'd0, rready}, 32'd0);

      // simultaneous AR and R-last handshakes at one in flight
      snap();
      req = 1'b1; addr = 32'h1c00_0200; arready = 1'b1;
      tick();
      req = 1'b0;
      tick();
      req = 1'b1; addr = 32'h1c00_0204;
      tick();
      req = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'haaaa_5555;
      tick();
      arready = 1'b0;
      chk("t4_data_ok_count", n_dok - d0, 1);
      chk("t4_rdata", last_rdata, 32'haaaa_5555);
      chk("t4_still_one_in_flight", {31'd0, rready}, 32'd1);
      chk("t4_arvalid_done", {31'd0, arvalid}, 32'd0);
      rlast = 1'b0; rdata = 32'h0bad_0bad;
      tick();
      rlast = 1'b1; rdata = 32'hcafe_f00d;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      chk("t4_nonlast_beat_silent", n_dok - d0, 2);
      chk("t4_rdata_last", last_rdata, 32'hcafe_f00d);
      chk("t4_rready_drained", {31'd0, rready}, 32'd0);

      // write requests and stray R beats are ignored
      snap();
      wr = 1'b1; req = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5a5a_5a5a;
      for (int i = 0; i < 10; i++) begin
         addr = 32'h1c00_1000 + 32'(4 * i);
         tick();
      end
      wr = 1'b0; req = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      chk("t5_addr_ok_count", n_aok - a0, 0);
      chk("t5_arvalid_cycles", n_arv - v0, 0);
      chk("t5_data_ok_count", n_dok - d0, 0);

      // asynchronous reset mid-transaction
      req = 1'b1; addr = 32'h1c00_0300; arready = 1'b0;
      tick();
      arready = 1'b1;
      tick();
      arready = 1'b0; addr = 32'h1c00_0304;
      tick();
      tick();
      chk("t6_busy_before_reset", {31'd0, arvalid}, 32'd1);
      chk("t6_inflight_before_reset", {31'd0, rready}, 32'd1);
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'h7777_7777; resetn = 1'b0;
      #1;
      chk("t6_async_arvalid", {31'd0, arvalid}, 32'd0);
      chk("t6_async_rready", {31'd0, rready}, 32'd0);
      chk("t6_async_addr_ok", {31'd0, addr_ok}, 32'd0);
      chk("t6_async_data_ok", {31'd0, data_ok}, 32'd0);
      tick();
      resetn = 1'b1; req = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      tick();
      chk("t6_cnt_cleared", {31'd0, rready}, 32'd0);
      snap();
      req = 1'b1; addr = 32'h1c00_0400; size = 2'd1;
      tick();
      req = 1'b0; arready = 1'b1;
      tick();
      arready = 1'b0;
      tick();
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      tick();
      chk("t6_post_addr_ok", n_aok - a0, 1);
      chk("t6_post_data_ok", n_dok - d0, 1);
      chk("t6_post_rdata", last_rdata, 32'h1234_5678);
      chk("t6_post_araddr", last_araddr, 32'h1c00_0400);
      chk("t6_post_arsize", {29'd0, last_arsize}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
